// File: rtl/fpu_div_iter.sv
// Iterative radix-2 restoring divider with valid/ready handshake, signed/unsigned
// operands, remainder or modulus output and a pass-through tag. Define FPU_DIV_FAST_PATH_EN for the early-exit path.
module fpu_div_iter #(
   parameter int WIDTH    = 27,
   parameter bit REM_MODE = 1'b1,
   parameter int TAG_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_tc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             divide_by_0,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t             state, state_next;
   logic [WIDTH-1:0]   a_r, b_r;
   logic               tc_r;
   logic [TAG_W-1:0]   tag_r;
   logic [WIDTH-1:0]   dvd;    // dividend shifts out, quotient bits shift in
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH:0]     prem;
   logic               sq, sr;
   logic [CNT_W-1:0]   cnt;

   logic               a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b, dz_q;
   logic [WIDTH:0]     sh, diff;
   logic               ge;
   logic [WIDTH-1:0]   q_sgn, r_sgn, q_fix, r_fix;
   logic               adjust;
   logic               fast_small, fast_one;

   always_comb begin
      a_neg  = tc_r & a_r[WIDTH-1];
      b_neg  = tc_r & b_r[WIDTH-1];
      mag_a  = a_neg ? (~a_r + ONE) : a_r;
      mag_b  = b_neg ? (~b_r + ONE) : b_r;
      b_zero = (b_r == '0);

      if (!tc_r)              dz_q = '1;
      else if (a_r[WIDTH-1])  dz_q = {1'b1, {(WIDTH-1){1'b0}}};
      else                    dz_q = {1'b0, {(WIDTH-1){1'b1}}};

      sh   = {prem[WIDTH-1:0], dvd[WIDTH-1]};
      diff = sh - {1'b0, dvs};
      ge   = (sh >= {1'b0, dvs});

      // Modulus takes the divisor's sign: pull the quotient toward -inf.
      q_sgn  = sq ? (~dvd + ONE) : dvd;
      r_sgn  = sr ? (~prem[WIDTH-1:0] + ONE) : prem[WIDTH-1:0];
      adjust = !REM_MODE && tc_r && (r_sgn != '0) && (a_r[WIDTH-1] != b_r[WIDTH-1]);
      q_fix  = adjust ? (q_sgn - ONE) : q_sgn;
      r_fix  = adjust ? (r_sgn + b_r) : r_sgn;

`ifdef FPU_DIV_FAST_PATH_EN
      fast_small = (mag_a < mag_b);
      fast_one   = (mag_b == ONE);
`else
      fast_small = 1'b0;
      fast_one   = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid && in_ready) state_next = PREP;
         PREP: begin
            if (b_zero)                     state_next = DONE;
            else if (fast_small || fast_one) state_next = FIX;
            else                            state_next = ITER;
         end
         ITER: if (cnt == CNT_ONE) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         divide_by_0 <= 1'b0;
         out_tag     <= '0;
         cnt         <= '0;
         a_r         <= '0;
         b_r         <= '0;
         tc_r        <= 1'b0;
         tag_r       <= '0;
         dvd         <= '0;
         dvs         <= '0;
         prem        <= '0;
         sq          <= 1'b0;
         sr          <= 1'b0;
      end else begin
         in_ready <= (state_next == IDLE);
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r   <= in_a;
                  b_r   <= in_b;
                  tc_r  <= in_tc;
                  tag_r <= in_tag;
               end
            end
            PREP: begin
               sq   <= a_neg ^ b_neg;
               sr   <= a_neg;
               dvs  <= mag_b;
               dvd  <= mag_a;
               prem <= '0;
               cnt  <= CNT_W'(WIDTH);
               if (b_zero) begin
                  divide_by_0 <= 1'b1;
                  remainder   <= a_r;
                  quotient    <= dz_q;
                  out_tag     <= tag_r;
                  out_valid   <= 1'b1;
               end else if (fast_small) begin
                  dvd  <= '0;
                  prem <= {1'b0, mag_a};
               end
            end
            ITER: begin
               prem <= ge ? diff : sh;
               dvd  <= {dvd[WIDTH-2:0], ge};
               cnt  <= cnt - CNT_ONE;
            end
            FIX: begin
               quotient  <= q_fix;
               remainder <= r_fix;
               out_tag   <= tag_r;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  divide_by_0 <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
